// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch / count-down timer core with a BCD time cascade (hh:mm:ss.mmm)
// and a first-word-fall-through lap-capture FIFO.
//
// Digit packing of every 36-bit time bus, MSB first:
//   {h1, h0, m1, m0, s1, s0, ms2, ms1, ms0}, 4 bits per digit.
//
// All control inputs are single-cycle pulses. Each pulse acts on the falling
// edge of NEclk that samples it. There is no valid/ready backpressure. The
// effect is visible on the registered outputs after that edge. On a single
// edge the priority is reset > clear > load > start_stop > tick.
module stopwatch_lap_ctrl #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 1000,
    parameter int LAP_DEPTH = 8,
    parameter int HR_MAX    = 99
) (
    input  logic                         NEclk,
    input  logic                         reset,
    input  logic                         start_stop,
    input  logic                         clear,
    input  logic                         load,
    input  logic                         mode_down,
    input  logic [35:0]                  preset_bcd,
    input  logic                         lap,
    input  logic                         lap_rd,
    output logic [35:0]                  live_bcd,
    output logic                         running,
    output logic                         expired,
    output logic [35:0]                  lap_bcd,
    output logic                         lap_empty,
    output logic                         lap_full,
    output logic                         lap_ovf,
    output logic [$clog2(LAP_DEPTH):0]   lap_count
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int AW  = $clog2(LAP_DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [3:0]    HR_H1    = 4'(HR_MAX / 10);
    localparam logic [3:0]    HR_H0    = 4'(HR_MAX % 10);
    localparam logic [35:0]   MAX_BCD  = {HR_H1, HR_H0, 4'd5, 4'd9, 4'd5, 4'd9,
                                          4'd9, 4'd9, 4'd9};

    // Largest legal value of digit i below the hours field (s1 and m1 are tens of 60).
    function automatic logic [3:0] digit_max(input int i);
        return (i == 4 || i == 6) ? 4'd5 : 4'd9;
    endfunction

    logic [PW-1:0]      presc;
    logic [8:0][3:0]    cur;
    logic [8:0][3:0]    pre;
    logic [8:0][3:0]    up_val;
    logic [8:0][3:0]    dn_val;
    logic [8:0][3:0]    clamp_val;
    logic               ss_ok;

    assign cur = live_bcd;
    assign pre = preset_bcd;

    // A start press is refused when stopped in down mode with nothing left to count.
    assign ss_ok = running || !mode_down || (live_bcd != 36'd0);

    // One-tick increment with carries through ms, s, min and hours in a single edge.
    always_comb begin
        logic carry;
        up_val = cur;
        carry  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (carry) begin
                if (cur[i] == digit_max(i)) begin
                    up_val[i] = 4'd0;
                end else begin
                    up_val[i] = cur[i] + 4'd1;
                    carry     = 1'b0;
                end
            end
        end
        if (carry) begin
            if (cur[7] == 4'd9) begin
                up_val[7] = 4'd0;
                up_val[8] = cur[8] + 4'd1;
            end else begin
                up_val[7] = cur[7] + 4'd1;
            end
        end
    end

    // One-tick decrement with borrows through the same field limits.
    always_comb begin
        logic borrow;
        dn_val = cur;
        borrow = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (borrow) begin
                if (cur[i] == 4'd0) begin
                    dn_val[i] = digit_max(i);
                end else begin
                    dn_val[i] = cur[i] - 4'd1;
                    borrow    = 1'b0;
                end
            end
        end
        if (borrow) begin
            if (cur[7] == 4'd0) begin
                dn_val[7] = 4'd9;
                dn_val[8] = cur[8] - 4'd1;
            end else begin
                dn_val[7] = cur[7] - 4'd1;
            end
        end
    end

    // Clamp each preset digit to its field maximum; hours are clamped as a whole to HR_MAX.
    always_comb begin
        logic [3:0] h1c;
        logic [3:0] h0c;
        int         hours;
        clamp_val = pre;
        for (int i = 0; i < 7; i++) begin
            clamp_val[i] = (pre[i] > digit_max(i)) ? digit_max(i) : pre[i];
        end
        h1c   = (pre[8] > 4'd9) ? 4'd9 : pre[8];
        h0c   = (pre[7] > 4'd9) ? 4'd9 : pre[7];
        hours = int'(h1c) * 10 + int'(h0c);
        if (hours > HR_MAX) begin
            clamp_val[8] = HR_H1;
            clamp_val[7] = HR_H0;
        end else begin
            clamp_val[8] = h1c;
            clamp_val[7] = h0c;
        end
    end

    // Time base, run flag and time register; prescaler only moves on plain running edges.
    always_ff @(negedge NEclk) begin
        if (reset) begin
            live_bcd <= 36'd0;
            running  <= 1'b0;
            expired  <= 1'b0;
            presc    <= '0;
        end else begin
            expired <= 1'b0;
            if (clear) begin
                live_bcd <= 36'd0;
                running  <= 1'b0;
                presc    <= '0;
            end else if (load && !running) begin
                live_bcd <= clamp_val;
                presc    <= '0;
            end else if (start_stop) begin
                if (ss_ok) begin
                    running <= ~running;
                end
            end else if (running) begin
                if (presc == PRE_LAST) begin
                    presc <= '0;
                    if (mode_down) begin
                        if (live_bcd == 36'd0) begin
                            running <= 1'b0;
                            expired <= 1'b1;
                        end else begin
                            live_bcd <= dn_val;
                            if (dn_val == '0) begin
                                running <= 1'b0;
                                expired <= 1'b1;
                            end
                        end
                    end else if (live_bcd == MAX_BCD) begin
                        running <= 1'b0;
                        expired <= 1'b1;
                    end else begin
                        live_bcd <= up_val;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    // ---------------- lap FIFO ----------------
    logic [35:0]   mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_next;
    logic          do_wr;
    logic          do_rd;

    assign lap_empty  = (lap_count == '0);
    assign lap_full   = (lap_count == CW'(LAP_DEPTH));
    assign do_rd      = lap_rd && !lap_empty;
    assign do_wr      = lap && (!lap_full || lap_rd);
    assign rd_next    = rd_ptr + AW'(do_rd);
    assign count_next = lap_count + CW'(do_wr) - CW'(do_rd);

    // Lap storage; captures the time as registered before this edge's tick.
    always_ff @(negedge NEclk) begin
        if (do_wr && !reset && !clear) begin
            mem[wr_ptr] <= live_bcd;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and the registered head word.
    always_ff @(negedge NEclk) begin
        if (reset || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lap_count <= '0;
            lap_ovf   <= 1'b0;
            lap_bcd   <= 36'd0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_next;
            lap_count <= count_next;
            if (lap && lap_full && !lap_rd) begin
                lap_ovf <= 1'b1;
            end
            if (count_next == '0) begin
                lap_bcd <= 36'd0;
            end else if (do_wr && (rd_next == wr_ptr)) begin
                lap_bcd <= live_bcd;
            end else begin
                lap_bcd <= mem[rd_next];
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl with DIV = 4000/1000 = 4.
// A second instance with HR_MAX=23 shares all inputs and is used for the
// hour-clamp checks.
module tb_stopwatch_lap_ctrl;

    logic        NEclk;
    logic        reset;
    logic        start_stop;
    logic        clear;
    logic        load;
    logic        mode_down;
    logic [35:0] preset_bcd;
    logic        lap;
    logic        lap_rd;

    logic [35:0] live_bcd;
    logic        running;
    logic        expired;
    logic [35:0] lap_bcd;
    logic        lap_empty;
    logic        lap_full;
    logic        lap_ovf;
    logic [3:0]  lap_count;

    logic [35:0] live_bcd_23;
    logic        running_23;
    logic        expired_23;
    logic [35:0] lap_bcd_23;
    logic        lap_empty_23;
    logic        lap_full_23;
    logic        lap_ovf_23;
    logic [3:0]  lap_count_23;

    int checks = 0;
    int errors = 0;

    stopwatch_lap_ctrl #(.CLK_HZ(4000), .TICK_HZ(1000), .LAP_DEPTH(8), .HR_MAX(99)) dut (
        .NEclk(NEclk), .reset(reset), .start_stop(start_stop), .clear(clear),
        .load(load), .mode_down(mode_down), .preset_bcd(preset_bcd), .lap(lap),
        .lap_rd(lap_rd), .live_bcd(live_bcd), .running(running), .expired(expired),
        .lap_bcd(lap_bcd), .lap_empty(lap_empty), .lap_full(lap_full),
        .lap_ovf(lap_ovf), .lap_count(lap_count)
    );

    stopwatch_lap_ctrl #(.CLK_HZ(4000), .TICK_HZ(1000), .LAP_DEPTH(8), .HR_MAX(23)) dut23 (
        .NEclk(NEclk), .reset(reset), .start_stop(start_stop), .clear(clear),
        .load(load), .mode_down(mode_down), .preset_bcd(preset_bcd), .lap(lap),
        .lap_rd(lap_rd), .live_bcd(live_bcd_23), .running(running_23),
        .expired(expired_23), .lap_bcd(lap_bcd_23), .lap_empty(lap_empty_23),
        .lap_full(lap_full_23), .lap_ovf(lap_ovf_23), .lap_count(lap_count_23)
    );

    // clock / reset
    initial NEclk = 1'b0;
    always #5 NEclk = ~NEclk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance n active (falling) edges, then settle 1 time unit.
    task automatic edges(input int n);
        repeat (n) begin
            @(negedge NEclk);
            #1;
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; edges(1); start_stop = 1'b0;
    endtask

    task automatic pulse_load(input logic [35:0] v);
        preset_bcd = v; load = 1'b1; edges(1); load = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; edges(1); clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1; edges(1); lap = 1'b0;
    endtask

    task automatic pulse_rd();
        lap_rd = 1'b1; edges(1); lap_rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_stop = 1'b0; clear = 1'b0; load = 1'b0;
        mode_down = 1'b0; preset_bcd = 36'd0; lap = 1'b0; lap_rd = 1'b0;
        edges(2);
        chk("rst_live", live_bcd, 36'd0);
        chk("rst_running", 36'(running), 36'd0);
        chk("rst_expired", 36'(expired), 36'd0);
        chk("rst_lap_bcd", lap_bcd, 36'd0);
        chk("rst_empty", 36'(lap_empty), 36'd1);
        chk("rst_full", 36'(lap_full), 36'd0);
        chk("rst_ovf", 36'(lap_ovf), 36'd0);
        chk("rst_count", 36'(lap_count), 36'd0);
        reset = 1'b0;
        edges(1);

        // Count up from zero
        pulse_ss();
        chk("start_running", 36'(running), 36'd1);
        edges(3);
        chk("up_3edges", live_bcd, 36'h000000000);
        edges(1);
        chk("up_4edges", live_bcd, 36'h000000001);
        edges(3996);
        chk("up_4000edges", live_bcd, 36'h000001000);
        edges(2);
        pulse_ss();
        chk("pause_running", 36'(running), 36'd0);
        edges(10);
        chk("pause_hold", live_bcd, 36'h000001000);
        pulse_ss();
        edges(2);
        chk("resume_phase", live_bcd, 36'h000001001);
        pulse_ss();

        // Carry across seconds into minutes
        pulse_load(36'h000059998);
        chk("load_up", live_bcd, 36'h000059998);
        pulse_ss();
        edges(8);
        chk("carry_min", live_bcd, 36'h000100000);
        pulse_ss();

        // Up-count saturation at HR_MAX
        pulse_load(36'h995959999);
        pulse_ss();
        edges(3);
        chk("sat_pre_running", 36'(running), 36'd1);
        edges(1);
        chk("sat_hold", live_bcd, 36'h995959999);
        chk("sat_expired", 36'(expired), 36'd1);
        chk("sat_running", 36'(running), 36'd0);
        edges(1);
        chk("sat_expired_pulse", 36'(expired), 36'd0);

        // Count down
        mode_down = 1'b1;
        pulse_load(36'h000100000);
        pulse_ss();
        edges(4);
        chk("down_borrow", live_bcd, 36'h000059999);
        pulse_ss();
        pulse_load(36'h000000002);
        pulse_ss();
        edges(4);
        chk("down_1", live_bcd, 36'h000000001);
        chk("down_1_expired", 36'(expired), 36'd0);
        edges(4);
        chk("down_zero", live_bcd, 36'd0);
        chk("down_expired", 36'(expired), 36'd1);
        chk("down_running", 36'(running), 36'd0);
        edges(1);
        chk("down_expired_pulse", 36'(expired), 36'd0);
        pulse_ss();
        chk("down_zero_start_ignored", 36'(running), 36'd0);

        // Preset clamping (HR_MAX=23 instance) and load-while-running
        mode_down = 1'b0;
        pulse_load(36'hA57090F0C);
        chk("clamp23", live_bcd_23, 36'h235050909);
        pulse_ss();
        edges(4);
        chk("clamp23_tick", live_bcd_23, 36'h235050910);
        pulse_load(36'h000000000);
        chk("load_running_noop", live_bcd_23, 36'h235050910);
        chk("load_running_run", 36'(running_23), 36'd1);
        pulse_ss();

        // Lap FIFO fill, overflow, drain
        pulse_clear();
        chk("clear_live", live_bcd, 36'd0);
        pulse_ss();
        for (int k = 0; k < 9; k++) begin
            edges(3);
            pulse_lap();
        end
        pulse_ss();
        chk("lap_full", 36'(lap_full), 36'd1);
        chk("lap_ovf", 36'(lap_ovf), 36'd1);
        chk("lap_count8", 36'(lap_count), 36'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lap_pop%0d", k), lap_bcd, 36'(k));
            pulse_rd();
        end
        chk("drain_empty", 36'(lap_empty), 36'd1);
        chk("drain_bcd", lap_bcd, 36'd0);
        chk("drain_count", 36'(lap_count), 36'd0);
        chk("ovf_sticky", 36'(lap_ovf), 36'd1);

        // Full FIFO with simultaneous lap and lap_rd
        for (int k = 1; k <= 8; k++) begin
            pulse_load(36'h000000100 + 36'(k));
            pulse_lap();
        end
        chk("refill_count", 36'(lap_count), 36'd8);
        pulse_load(36'h000000200);
        lap = 1'b1; lap_rd = 1'b1; edges(1); lap = 1'b0; lap_rd = 1'b0;
        chk("wr_rd_full_count", 36'(lap_count), 36'd8);
        chk("wr_rd_full_fullflag", 36'(lap_full), 36'd1);
        for (int k = 2; k <= 8; k++) begin
            chk($sformatf("wr_rd_pop%0d", k), lap_bcd, 36'h000000100 + 36'(k));
            pulse_rd();
        end
        chk("wr_rd_last", lap_bcd, 36'h000000200);
        pulse_rd();
        chk("wr_rd_empty", 36'(lap_empty), 36'd1);

        // Empty FIFO: read ignored; write+read writes only
        pulse_rd();
        chk("empty_rd_count", 36'(lap_count), 36'd0);
        pulse_load(36'h000000333);
        lap = 1'b1; lap_rd = 1'b1; edges(1); lap = 1'b0; lap_rd = 1'b0;
        chk("empty_wr_rd_count", 36'(lap_count), 36'd1);
        chk("empty_wr_rd_head", lap_bcd, 36'h000000333);

        // Clear mid-count
        pulse_ss();
        edges(10);
        pulse_lap();
        pulse_clear();
        chk("clr_live", live_bcd, 36'd0);
        chk("clr_running", 36'(running), 36'd0);
        chk("clr_expired", 36'(expired), 36'd0);
        chk("clr_lap_bcd", lap_bcd, 36'd0);
        chk("clr_empty", 36'(lap_empty), 36'd1);
        chk("clr_full", 36'(lap_full), 36'd0);
        chk("clr_ovf", 36'(lap_ovf), 36'd0);
        chk("clr_count", 36'(lap_count), 36'd0);
        edges(8);
        chk("clr_stays_stopped", live_bcd, 36'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Parametrised stopwatch/timer core and successor to the fixed 1 kHz count-up watch chain. It divides the system clock to a TICK_HZ time base and keeps time directly in a BCD cascade (hh:mm:ss.mmm), so no binary-to-BCD stage is needed. It adds count-down mode with preset load and expiry, start/stop/clear control, and a LAP_DEPTH-deep lap-capture FIFO. It sits between the board pushbutton debouncers and the 7-segment multiplexer.

Parameters:
CLK_HZ, 50000000, NEclk frequency in Hz.
TICK_HZ, 1000, time-base rate. CLK_HZ/TICK_HZ must be an integer ≥2. One tick advances the ms field by 1.
LAP_DEPTH, 8, lap FIFO entries (power of 2, ≥2).
HR_MAX, 99, maximum hours value (1..99).

Ports:
NEclk  in  1  system clock; all state updates on its falling edge.
reset  in  1  synchronous, active-high reset.
start_stop  in  1  one-cycle pulse; toggles running.
clear  in  1  one-cycle pulse; zero time, stop, flush laps.
load  in  1  one-cycle pulse; load preset_bcd (ignored while running).
mode_down  in  1  0 = count up, 1 = count down; sampled every tick.
preset_bcd  in  36  {h1,h0,m1,m0,s1,s0,ms2,ms1,ms0}, 4 bits per digit.
lap  in  1  one-cycle pulse; capture live time into the FIFO.
lap_rd  in  1  one-cycle pulse; pop the FIFO head.
live_bcd  out  36  current time, same packing as preset_bcd.
running  out  1  1 while counting.
expired  out  1  one-cycle pulse on down-count reaching zero or up-count saturation.
lap_bcd  out  36  FIFO head (first-word-fall-through); 0 when empty.
lap_empty  out  1  FIFO empty.
lap_full  out  1  FIFO full.
lap_ovf  out  1  sticky; a lap was dropped.
lap_count  out  $clog2(LAP_DEPTH)+1  entries held.

Behaviour:
- Reset: live_bcd=0, running=0, expired=0, prescaler=0, FIFO empty, lap_bcd=0, lap_empty=1, lap_full=0, lap_ovf=0, lap_count=0.
- Control priority, per edge: reset > clear > load > start_stop > tick.
- Prescaler:
  - Counts 0..DIV-1, where DIV=CLK_HZ/TICK_HZ. It advances only while running and is frozen while stopped, so the sub-tick fraction is kept.
  - The tick is asserted on the edge where the prescaler equals DIV-1; the prescaler then wraps to 0.
  - clear and load zero the prescaler.
  - The first tick after start occurs DIV edges after start_stop.
- Digit cascade, up mode: ms 000-999 → s 00-59 → min 00-59 → h 00-HR_MAX, with carries applied in the same edge. At HR_MAX:59:59.999 the next tick holds the value, clears running and pulses expired. The counter never wraps.
- Digit cascade, down mode: borrows go through the same limits (ms 000 → 999 with s-1, etc.). When the value reaches 00:00:00.000, running clears on that same edge and expired pulses for one cycle.
- start_stop behaviour:
  - In down mode with live_bcd=0, start_stop is ignored (running stays 0).
  - start_stop coincident with a tick: the toggle wins and that tick is not applied.
- mode_down may change while running; the new direction takes effect from the next tick.
- load (stopped only): each preset digit is clamped to its field maximum (s1/m1 ≤5, hours ≤HR_MAX, others ≤9). A clamped value is then loaded. load while running is a no-op.
- clear: live_bcd=0, running=0, prescaler=0, FIFO flushed, lap_ovf=0. Clear is legal at any time, including mid-count.
- Lap FIFO:
  - lap captures live_bcd as registered before this edge's tick update. Capture is legal whether running or stopped.
  - Full: with lap and no lap_rd, the lap is dropped and lap_ovf is set.
  - Empty: lap_rd is ignored.
  - lap and lap_rd on the same edge: when full, both take effect and the count is unchanged. When empty, only the write takes effect.
  - lap_bcd reflects the new head on the edge after a pop or after the first write.
  - Pointers wrap modulo LAP_DEPTH.
- Latency: every output is registered. Controls act on the edge that samples them, and outputs are visible after that edge.

Test Plan:
- Bench uses CLK_HZ=4000, TICK_HZ=1000, DIV=4. Reset, then start_stop → running=1. After 4 edges live_bcd=00:00:00.001; after 4000 edges 00:00:01.000. Pause for 10 edges: value is held and the prescaler phase is kept.
- Load preset 00:00:59.998 in up mode, start → after 8 edges 00:01:00.000. Load 99:59:59.999 (HR_MAX=99), start → after 4 edges the value is held, expired pulses once and running=0.
- mode_down=1, load 00:01:00.000, start → after 4 edges 00:00:59.999. Load 00:00:00.002, start → at 8 edges value 0, expired=1 for one cycle, running=0. A further start_stop is ignored.
- Load preset with s1=9, h=A5 (HR_MAX=23) → live_bcd shows s1=5, h=23. Load while running → no change.
- With LAP_DEPTH=8, issue 9 laps at distinct times → lap_full=1, lap_ovf=1, lap_count=8. The 9th value is absent. 8 lap_rd pulses return the values in capture order, then lap_empty=1 and lap_bcd=0.
- Full FIFO, lap+lap_rd on the same edge → count stays 8 and the oldest entry is replaced in order. clear mid-count → all outputs return to reset values on the next edge.
